// File: rtl/xnor_seq_compare.sv
// Multi-cycle bitwise equality comparator: walks LANES bit positions per clock
// and reports word equality plus a match (XNOR) or mismatch (XOR) count.
module xnor_seq_compare #(
    parameter int  WIDTH = 8,
    parameter int  LANES = 1,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CW-1:0]    count
);

    localparam int N  = WIDTH / LANES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              mode_r;
    logic [IW-1:0]     idx_r;
    logic [CW-1:0]     acc_r;
    logic              busy_r;
    logic              done_r;
    logic              equal_r;
    logic [CW-1:0]     count_r;
    logic [WIDTH-1:0]  xm_all_s;
    logic [CW-1:0]     matches_s;
    logic              last_s;

    function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Current slice match count folded into the running accumulator.
    always_comb begin
        xm_all_s  = ~(a_r ^ b_r) >> (int'(idx_r) * LANES);
        matches_s = acc_r + popcount(xm_all_s[LANES-1:0]);
        last_s    = (idx_r == IW'(N - 1));
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, accumulation and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            mode_r  <= 1'b0;
            idx_r   <= '0;
            acc_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            equal_r <= 1'b0;
            count_r <= '0;
        end else begin
            busy_r <= (state_s == S_RUN);
            done_r <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        mode_r <= mode;
                        acc_r  <= '0;
                        idx_r  <= '0;
                    end
                end
                S_RUN: begin
                    acc_r <= matches_s;
                    idx_r <= idx_r + IW'(1);
                    // Results only move on the final pass so they hold while busy.
                    if (last_s) begin
                        count_r <= mode_r ? (CW'(WIDTH) - matches_s) : matches_s;
                        equal_r <= (matches_s == CW'(WIDTH));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign equal = equal_r;
    assign count = count_r;

endmodule

// File: tb/tb_xnor_seq_compare.sv
// Scoreboard bench for xnor_seq_compare: three instances (8/1, 8/4, 2/1),
// expected results queued at issue time and checked by per-instance monitors.
module tb_xnor_seq_compare;

    typedef struct {
        logic [3:0] cnt;
        logic       eq;
        int         issue;
        bit         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, mode0, busy0, done0, equal0;
    logic [7:0] a0, b0;
    logic [3:0] count0;
    logic       start4, mode4, busy4, done4, equal4;
    logic [7:0] a4, b4;
    logic [3:0] count4;
    logic       start2, mode2, busy2, done2, equal2;
    logic [1:0] a2, b2;
    logic [1:0] count2;

    exp_t q0[$];
    exp_t q4[$];
    exp_t q2[$];
    int   vec_count = 0;
    int   err_count = 0;
    int   cyc = 0;
    logic rst_seen = 1'b1;

    xnor_seq_compare #(.WIDTH(8), .LANES(1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .equal(equal0), .count(count0));
    xnor_seq_compare #(.WIDTH(8), .LANES(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .equal(equal4), .count(count4));
    xnor_seq_compare #(.WIDTH(2), .LANES(1)) u2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .equal(equal2), .count(count2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit, 1-lane instance: results, latency, busy span, hold.
    int         busy_len = 0;
    int         last_done = 0;
    logic [3:0] hold_cnt = 4'd0;
    logic       hold_eq = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            chk("u0_rst_busy", busy0, 0);
            chk("u0_rst_done", done0, 0);
            chk("u0_rst_count", count0, 0);
            chk("u0_rst_equal", equal0, 0);
            hold_cnt = 4'd0;
            hold_eq  = 1'b0;
            busy_len = 0;
        end else if (done0) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_done", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("u0_count", count0, e.cnt);
                chk("u0_equal", equal0, e.eq);
                chk("u0_busy_cycles", busy_len, 8);
                chk("u0_busy_at_done", busy0, 0);
                if (e.issue >= 0) chk("u0_latency", cyc, e.issue + 9);
                if (e.gap) chk("u0_done_gap", cyc - last_done, 10);
                hold_cnt = e.cnt;
                hold_eq  = e.eq;
            end
            last_done = cyc;
            busy_len  = 0;
        end else begin
            chk("u0_hold_count", count0, hold_cnt);
            chk("u0_hold_equal", equal0, hold_eq);
            if (busy0) busy_len++;
        end
    end

    // Monitors for the 4-lane and 2-bit instances.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_seen && done4) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_done", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("u4_count", count4, e.cnt);
                chk("u4_equal", equal4, e.eq);
                chk("u4_latency", cyc, e.issue + 3);
            end
        end
        if (!rst_seen && done2) begin
            if (q2.size() == 0) begin
                chk("u2_unexpected_done", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("u2_count", count2, e.cnt);
                chk("u2_equal", equal2, e.eq);
                chk("u2_latency", cyc, e.issue + 3);
            end
        end
    end

    task automatic run0(input logic [7:0] av, input logic [7:0] bv, input logic m,
                        input logic [3:0] ec, input logic ee, input bit scr);
        exp_t e;
        int   t;
        e.cnt = ec; e.eq = ee; e.issue = cyc; e.gap = 1'b0;
        q0.push_back(e);
        a0 = av; b0 = bv; mode0 = m; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t = 0;
        while (!done0 && t < 40) begin
            if (scr) begin
                start0 = ~start0;
                a0     = ~a0;
                b0     = b0 + 8'd1;
                mode0  = ~mode0;
            end
            @(negedge clk);
            t++;
        end
        start0 = 1'b0;
        chk("u0_done_seen", done0, 1);
        @(negedge clk);
    endtask

    task automatic run_small(input int which, input logic [7:0] av, input logic [7:0] bv,
                             input logic m, input logic [3:0] ec, input logic ee);
        exp_t e;
        int   t;
        e.cnt = ec; e.eq = ee; e.issue = cyc; e.gap = 1'b0;
        if (which == 4) begin
            q4.push_back(e);
            a4 = av; b4 = bv; mode4 = m; start4 = 1'b1;
        end else begin
            q2.push_back(e);
            a2 = av[1:0]; b2 = bv[1:0]; mode2 = m; start2 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
        t = 0;
        while (!((which == 4) ? done4 : done2) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("small_done_seen", (which == 4) ? done4 : done2, 1);
        @(negedge clk);
    endtask

    initial begin
        exp_t       e;
        int         nd;
        int         t;
        logic [1:0] x;
        reset = 1'b1;
        start0 = 1'b0; mode0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
        start4 = 1'b0; mode4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
        start2 = 1'b0; mode2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run0(8'hA5, 8'hA5, 1'b0, 4'd8, 1'b1, 1'b0);
        run0(8'hF0, 8'h0F, 1'b1, 4'd8, 1'b0, 1'b0);
        run0(8'hF0, 8'h0F, 1'b0, 4'd0, 1'b0, 1'b0);
        run0(8'hC3, 8'h81, 1'b0, 4'd6, 1'b0, 1'b1);

        // Abort: reset sampled on edge k+3 of a run, no result expected.
        a0 = 8'hFF; b0 = 8'h00; mode0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        run0(8'h0F, 8'h0E, 1'b1, 4'd1, 1'b0, 1'b0);

        // Back-to-back with start held high.
        e.cnt = 4'd7; e.eq = 1'b0; e.issue = cyc; e.gap = 1'b0; q0.push_back(e);
        e.cnt = 4'd8; e.eq = 1'b0; e.issue = -1;  e.gap = 1'b1; q0.push_back(e);
        e.cnt = 4'd0; e.eq = 1'b1; e.issue = -1;  e.gap = 1'b1; q0.push_back(e);
        a0 = 8'h3C; b0 = 8'h3D; mode0 = 1'b0; start0 = 1'b1;
        nd = 0;
        t  = 0;
        while (nd < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (done0) begin
                nd++;
                case (nd)
                    1: begin a0 = 8'hFF; b0 = 8'h00; mode0 = 1'b1; end
                    2: begin a0 = 8'h5A; b0 = 8'h5A; mode0 = 1'b1; end
                    default: start0 = 1'b0;
                endcase
            end
        end
        start0 = 1'b0;
        chk("u0_burst_dones", nd, 3);
        repeat (2) @(negedge clk);

        run_small(4, 8'hCA, 8'hAA, 1'b0, 4'd6, 1'b0);
        run_small(4, 8'h12, 8'h12, 1'b1, 4'd0, 1'b1);
        run_small(4, 8'hF0, 8'h0F, 1'b0, 4'd0, 1'b0);

        for (int m = 0; m < 2; m++) begin
            for (int ai = 0; ai < 4; ai++) begin
                for (int bi = 0; bi < 4; bi++) begin
                    x = 2'(ai) ^ 2'(bi);
                    run_small(2, 8'(ai), 8'(bi), m[0],
                              (m == 1) ? 4'($countones(x)) : 4'($countones(~x)),
                              (x == 2'b00));
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
